// File: rtl/framebuffer_arbiter.sv
// Cycle-by-cycle arbiter sharing one single-port frame-buffer RAM between the
// display scanner (read-only, priority) and the host loader (read/write).
module framebuffer_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAGES = RD_LATENCY + 1;

  typedef struct packed {
    logic valid;
    logic is_host;
  } tag_t;

  logic [CNT_W-1:0] wait_cnt;
  logic             wait_sat;
  tag_t             new_tag;
  tag_t             pipe [STAGES];

  assign wait_sat = (wait_cnt == CNT_W'(MAX_WAIT));

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    disp_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      if (host_req && (!disp_req || wait_sat))
        host_gnt = 1'b1;
      else if (disp_req)
        disp_gnt = 1'b1;
    end
  end

  always_comb begin
    new_tag.valid   = disp_gnt || (host_gnt && !host_we);
    new_tag.is_host = host_gnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (host_req && !host_gnt) begin
      if (!wait_sat)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_address      <= '0;
      mem_data         <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      mem_write_enable <= host_gnt && host_we;
      if (host_gnt) begin
        mem_address <= host_addr;
        mem_data    <= host_wdata;
      end else if (disp_gnt) begin
        mem_address <= disp_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= new_tag;
      for (int unsigned i = 1; i < STAGES; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  // The last tag stage lines up with mem_q for the address it owns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      disp_rdata  <= '0;
      host_rdata  <= '0;
    end else begin
      disp_rvalid <= pipe[STAGES-1].valid && !pipe[STAGES-1].is_host;
      host_rvalid <= pipe[STAGES-1].valid &&  pipe[STAGES-1].is_host;
      if (pipe[STAGES-1].valid && !pipe[STAGES-1].is_host)
        disp_rdata <= mem_q;
      if (pipe[STAGES-1].valid && pipe[STAGES-1].is_host)
        host_rdata <= mem_q;
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a write-first, 1-cycle RAM model.
module tb_framebuffer_arbiter;
  logic        clk;
  logic        rst;
  logic        disp_req;
  logic [9:0]  disp_addr;
  logic        disp_gnt;
  logic [47:0] disp_rdata;
  logic        disp_rvalid;
  logic        host_req;
  logic        host_we;
  logic [9:0]  host_addr;
  logic [47:0] host_wdata;
  logic        host_gnt;
  logic [47:0] host_rdata;
  logic        host_rvalid;
  logic [9:0]  mem_address;
  logic [47:0] mem_data;
  logic        mem_write_enable;
  logic [47:0] mem_q;

  logic [47:0] ram [1024];

  int n_checks;
  int n_fail;

  framebuffer_arbiter #(.ADDR_W(10), .DATA_W(48), .MAX_WAIT(4), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_write_enable(mem_write_enable), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_enable) begin
      ram[mem_address] <= mem_data;
      mem_q            <= mem_data;
    end else begin
      mem_q <= ram[mem_address];
    end
  end

  task automatic host_write(input logic [9:0] a, input logic [47:0] d);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic test_reset;
    logic seen;
    disp_req = 1'b1; host_req = 1'b1; host_we = 1'b1;
    disp_addr = 10'h155; host_addr = 10'h2AA; host_wdata = 48'hFFFF_FFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({disp_gnt, host_gnt, disp_rvalid, host_rvalid, mem_write_enable} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 00000",
               {disp_gnt, host_gnt, disp_rvalid, host_rvalid, mem_write_enable});
    end
    n_checks++;
    if ({mem_address, mem_data} !== 58'h0) begin
      n_fail++;
      $display("FAIL reset_mem: addr %h data %h want 0", mem_address, mem_data);
    end
    n_checks++;
    if ({disp_rdata, host_rdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: disp %h host %h want 0", disp_rdata, host_rdata);
    end
    @(negedge clk);
    rst = 1'b0; disp_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 10'h005;
    #1;
    n_checks++;
    if (disp_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midread_gnt: got %b want 1", disp_gnt);
    end
    @(negedge clk);
    disp_req = 1'b0; rst = 1'b1;
    #1;
    n_checks++;
    if ({disp_gnt, disp_rvalid, mem_address} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_midread_clear: gnt %b rvalid %b addr %h want 0",
               disp_gnt, disp_rvalid, mem_address);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (disp_rvalid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: disp_rvalid seen %b want 0", seen);
    end
  endtask

  task automatic test_single_display;
    host_write(10'h010, 48'hAAAA_5555_0F0F);
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 10'h010;
    #1;
    n_checks++;
    if ({disp_gnt, host_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_gnt: got %b want 10", {disp_gnt, host_gnt});
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      disp_req = 1'b0;
      #1;
      n_checks++;
      if (disp_rvalid !== (k == 3)) begin
        n_fail++;
        $display("FAIL single_rvalid_%0d: got %b want %b", k, disp_rvalid, (k == 3));
      end
      if (k >= 3) begin
        n_checks++;
        if (disp_rdata !== 48'hAAAA_5555_0F0F) begin
          n_fail++;
          $display("FAIL single_rdata_%0d: got %h want aaaa55550f0f", k, disp_rdata);
        end
      end
    end
  endtask

  task automatic test_write_read;
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FF; host_wdata = 48'h1234_5678_9ABC;
    #1;
    n_checks++;
    if (host_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_gnt: got %b want 1", host_gnt);
    end
    @(negedge clk);
    host_we = 1'b0;
    #1;
    n_checks++;
    if ({mem_write_enable, mem_address, mem_data} !== {1'b1, 10'h3FF, 48'h1234_5678_9ABC}) begin
      n_fail++;
      $display("FAIL wr_mem: we %b addr %h data %h want 1 3ff 123456789abc",
               mem_write_enable, mem_address, mem_data);
    end
    @(negedge clk);
    host_req = 1'b0;
    #1;
    n_checks++;
    if ({mem_write_enable, mem_address} !== {1'b0, 10'h3FF}) begin
      n_fail++;
      $display("FAIL rd_mem: we %b addr %h want 0 3ff", mem_write_enable, mem_address);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (host_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_early: host_rvalid %b want 0", host_rvalid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({host_rvalid, host_rdata} !== {1'b1, 48'h1234_5678_9ABC}) begin
      n_fail++;
      $display("FAIL rd_data: rvalid %b data %h want 1 123456789abc", host_rvalid, host_rdata);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({host_rvalid, disp_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_pulse: host %b disp %b want 00", host_rvalid, disp_rvalid);
    end
  endtask

  task automatic test_contention;
    logic eh;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      disp_req = 1'b1; disp_addr = 10'h021;
      host_req = (c != 4); host_we = 1'b0; host_addr = 10'h020;
      eh = (c == 9) || (c == 14);
      #1;
      n_checks++;
      if ({disp_gnt, host_gnt} !== {~eh, eh}) begin
        n_fail++;
        $display("FAIL contention_%0d: gnt dh %b want %b", c, {disp_gnt, host_gnt}, {~eh, eh});
      end
    end
    @(negedge clk);
    disp_req = 1'b0; host_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mixed;
    logic        eh, ed, edr, ehr;
    logic [47:0] ed_data;
    host_write(10'h001, 48'h0101_0101_0101);
    host_write(10'h002, 48'h0202_0202_0202);
    host_write(10'h100, 48'h1000_1000_1000);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      disp_req  = (c < 6);
      disp_addr = (c == 1 || c == 3) ? 10'h002 : 10'h001;
      host_req  = (c < 5); host_we = 1'b0; host_addr = 10'h100;
      eh  = (c == 4);
      ed  = (c < 6) && !eh;
      edr = (c >= 3 && c <= 6) || (c == 8);
      ehr = (c == 7);
      ed_data = (c == 4 || c == 6) ? 48'h0202_0202_0202 : 48'h0101_0101_0101;
      #1;
      n_checks++;
      if ({disp_gnt, host_gnt} !== {ed, eh}) begin
        n_fail++;
        $display("FAIL mixed_gnt_%0d: dh %b want %b", c, {disp_gnt, host_gnt}, {ed, eh});
      end
      n_checks++;
      if ({disp_rvalid, host_rvalid} !== {edr, ehr}) begin
        n_fail++;
        $display("FAIL mixed_rvalid_%0d: dh %b want %b", c, {disp_rvalid, host_rvalid}, {edr, ehr});
      end
      if (edr) begin
        n_checks++;
        if (disp_rdata !== ed_data) begin
          n_fail++;
          $display("FAIL mixed_drdata_%0d: got %h want %h", c, disp_rdata, ed_data);
        end
      end
      if (ehr) begin
        n_checks++;
        if (host_rdata !== 48'h1000_1000_1000) begin
          n_fail++;
          $display("FAIL mixed_hrdata_%0d: got %h want 100010001000", c, host_rdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      disp_req = 1'b0;
      host_req = (c < 8); host_we = (c < 8);
      host_addr = 10'(c); host_wdata = 48'h0000_1111_0000 + 48'(c);
      #1;
      if (c < 8) begin
        n_checks++;
        if (host_gnt !== 1'b1) begin
          n_fail++;
          $display("FAIL burst_gnt_%0d: got %b want 1", c, host_gnt);
        end
      end
      if (c >= 1 && c <= 8) begin
        n_checks++;
        if ({mem_write_enable, mem_address, mem_data} !==
            {1'b1, 10'(c - 1), 48'h0000_1111_0000 + 48'(c - 1)}) begin
          n_fail++;
          $display("FAIL burst_mem_%0d: we %b addr %h data %h want 1 %h %h", c,
                   mem_write_enable, mem_address, mem_data, 10'(c - 1),
                   48'h0000_1111_0000 + 48'(c - 1));
        end
      end
      if (c == 9) begin
        n_checks++;
        if (mem_write_enable !== 1'b0) begin
          n_fail++;
          $display("FAIL burst_we_end: got %b want 0", mem_write_enable);
        end
      end
      n_checks++;
      if ({disp_rvalid, host_rvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL burst_rvalid_%0d: dh %b want 00", c, {disp_rvalid, host_rvalid});
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    test_reset();
    test_single_display();
    test_write_read();
    test_contention();
    test_mixed();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
- Shares one single-port LED-matrix frame-buffer RAM (1024 x 48-bit) between two requesters: the display scanner (read-only) and the host loader (read/write).
- Sits between both requesters and the RAM's address/data/write-enable/q port. It replaces the static select line with cycle-by-cycle arbitration.
- The display has priority. A starvation counter bounds the host's wait.
- Read data is returned to the requesting side with a valid strobe.

Parameters:
- ADDR_W, 10, RAM address width (1024 words).
- DATA_W, 48, RAM word width (two RGB pixels x 24 bit).
- MAX_WAIT, 4, consecutive denied host cycles before the host is forced to win; legal range 1..15.
- RD_LATENCY, 1, RAM cycles from registered address to valid mem_q; legal range 1..3.

Ports:
- clk  in  1  single clock for the block and the RAM.
- reset  in  1  asynchronous, active-high reset.
- disp_req  in  1  display read request; held with disp_addr until granted.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rdata  out  DATA_W  display read data.
- disp_rvalid  out  1  disp_rdata valid this cycle.
- host_req  in  1  host request; held with host_we, host_addr and host_wdata until granted.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host request accepted this cycle.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host_rdata valid this cycle (reads only).
- mem_address  out  ADDR_W  RAM address (registered).
- mem_data  out  DATA_W  RAM write data (registered).
- mem_write_enable  out  1  RAM write strobe (registered).
- mem_q  in  DATA_W  RAM read data.

Behaviour:
- Reset (async, active-high) clears the following to 0:
  - disp_gnt, host_gnt, disp_rvalid, host_rvalid, disp_rdata, host_rdata;
  - mem_address, mem_data, mem_write_enable;
  - wait counter and read pipeline.
- Reads in flight when reset asserts are discarded and never produce rvalid.
- Grant logic is combinational from the req inputs and the registered wait counter. At most one gnt is high per cycle.
- A transfer is accepted on a rising edge where req && gnt.
- Arbitration rules:
  - Only disp_req: display wins.
  - Only host_req: host wins.
  - Both, with wait_cnt < MAX_WAIT: display wins.
  - Both, with wait_cnt == MAX_WAIT: host wins.
- Wait counter:
  - Increments (saturating at MAX_WAIT) on each cycle host_req=1 and host_gnt=0.
  - Clears on a host grant, or on any cycle with host_req=0.
- Accepted transfer, cycle N:
  - mem_address, mem_data and mem_write_enable are registered at edge N.
  - mem_write_enable is 1 only for an accepted host write, and only for that one cycle.
- Idle cycle: mem_write_enable=0. mem_address and mem_data hold their last value.
- Read pipeline:
  - An owner tag {valid, is_host} shifts through 1+RD_LATENCY stages.
  - The matching *_rvalid pulses for 1 cycle exactly 1+RD_LATENCY cycles after acceptance, with mem_q captured into *_rdata on that same edge.
- Reads:
  - *_rdata holds its value until the next valid read for that side.
  - Back-to-back reads are fully pipelined: throughput is 1 access/cycle and returns keep grant order.
- Writes produce no rvalid.
- Host read-after-write to the same address, in consecutive grants, returns the new data; the RAM is write-first and no bypass is needed.
- Addresses pass through unmodified, with no wrap or offset.
- Simultaneous requests when host_req drops in the same cycle the counter saturates: the display wins and the counter clears.

Test Plan:
- Reset mid-read: display read addr 0x005 accepted, reset asserted 1 cycle later → disp_rvalid never pulses; all outputs 0 during reset.
- Single display read: RAM[0x010]=0xAAAA_5555_0F0F, RD_LATENCY=1 → disp_gnt same cycle; disp_rvalid and that data exactly 2 cycles after accept.
- Host write then read: write 0x3FF ← 0x1234_5678_9ABC, then read 0x3FF → mem_write_enable high 1 cycle with mem_address=0x3FF; host_rvalid returns 0x1234_5678_9ABC.
- Contention, MAX_WAIT=4: disp_req and host_req both held high continuously → grants D,D,D,D,H repeating; host_gnt every 5th cycle; counter saturates at 4.
- Pipelined mixed reads: alternate display reads 0x001,0x002 with forced host read 0x100 → rvalids arrive in grant order, each tagged to the correct side, no lost or duplicated pulses.
- Host-only burst: 8 host writes to 0x000..0x007 with disp_req=0 → 8 consecutive grants, mem_write_enable high 8 cycles, no rvalid.
